// File: rtl/small_fifo_pkg.sv
// Shared helpers for the small_fifo_v3 buffer: constant log2 and wrapping pointer increment.
package small_fifo_pkg;

    // Bits needed to hold values 0..value-1.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        while ((64'(1) << r) < 64'(value)) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Pointer advance for a ring of arbitrary (non power-of-two) size.
    function automatic int unsigned ptr_next(input int unsigned ptr, input int unsigned depth);
        return (ptr >= depth - 1) ? 32'd0 : ptr + 32'd1;
    endfunction

endpackage

// File: rtl/small_fifo_ptr.sv
// Ring pointer for small_fifo_v3: advances on enable, wraps from DEPTH-1 to 0.
module small_fifo_ptr
    import small_fifo_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned PTR_W = clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             advance,
    output logic [PTR_W-1:0] ptr
);

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
        end else if (advance) begin
            ptr <= PTR_W'(ptr_next(32'(ptr), DEPTH));
        end
    end

endmodule

// File: rtl/small_fifo_v3.sv
// Synchronous FIFO with arbitrary depth, FWFT/registered read, programmable thresholds and sticky errors.
// Optional per-entry even parity with parity_err output when SMALL_FIFO_PARITY_EN is defined.
module small_fifo_v3
    import small_fifo_pkg::*;
#(
    parameter int unsigned WIDTH                = 72,
    parameter int unsigned DEPTH                = 8,
    parameter int unsigned PROG_FULL_THRESHOLD  = DEPTH - 1,
    parameter int unsigned PROG_EMPTY_THRESHOLD = 1,
    parameter int unsigned FWFT                 = 0,
    localparam int unsigned CNT_W               = clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             wr_en,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             nearly_full,
    output logic             prog_full,
    output logic             empty,
    output logic             prog_empty,
    output logic [CNT_W-1:0] data_count,
    output logic             overflow,
    output logic             underflow
`ifdef SMALL_FIFO_PARITY_EN
    ,
    output logic             parity_err
`endif
);

    localparam int unsigned PTR_W = clog2(DEPTH);
`ifdef SMALL_FIFO_PARITY_EN
    localparam int unsigned PAR_W = 1;
`else
    localparam int unsigned PAR_W = 0;
`endif
    localparam int unsigned MEM_W = WIDTH + PAR_W;

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_nxt;
    logic             wr_acc;
    logic             rd_acc;
    logic [MEM_W-1:0] mem [DEPTH];
    logic [MEM_W-1:0] wr_word;
    logic [MEM_W-1:0] rd_word;

    assign wr_acc    = wr_en && !full;
    assign rd_acc    = rd_en && !empty;
    assign count_nxt = count + CNT_W'(wr_acc) - CNT_W'(rd_acc);
    assign data_count = count;

    small_fifo_ptr #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_wr_ptr (
        .clk     (clk),
        .reset   (reset),
        .advance (wr_acc),
        .ptr     (wr_ptr)
    );

    small_fifo_ptr #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_rd_ptr (
        .clk     (clk),
        .reset   (reset),
        .advance (rd_acc),
        .ptr     (rd_ptr)
    );

    // Occupancy and all status flags are registered from the next count.
    always_ff @(posedge clk) begin
        if (reset) begin
            count       <= '0;
            full        <= 1'b0;
            nearly_full <= 1'b0;
            prog_full   <= 1'b0;
            empty       <= 1'b1;
            prog_empty  <= 1'b1;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
        end else begin
            count       <= count_nxt;
            full        <= (count_nxt == CNT_W'(DEPTH));
            nearly_full <= (count_nxt >= CNT_W'(DEPTH - 1));
            prog_full   <= (count_nxt >= CNT_W'(PROG_FULL_THRESHOLD));
            empty       <= (count_nxt == '0);
            prog_empty  <= (count_nxt <= CNT_W'(PROG_EMPTY_THRESHOLD));
            overflow    <= overflow  | (wr_en && full);
            underflow   <= underflow | (rd_en && empty);
        end
    end

`ifdef SMALL_FIFO_PARITY_EN
    assign wr_word = {^din, din};
`else
    assign wr_word = din;
`endif

    // Storage is deliberately not reset; pointers alone define validity.
    always_ff @(posedge clk) begin
        if (!reset && wr_acc) begin
            mem[wr_ptr] <= wr_word;
        end
    end

    assign rd_word = mem[rd_ptr];

    generate
        if (FWFT != 0) begin : g_fwft
            assign dout = empty ? '0 : rd_word[WIDTH-1:0];
`ifdef SMALL_FIFO_PARITY_EN
            assign parity_err = !empty && ((^rd_word[WIDTH-1:0]) != rd_word[WIDTH]);
`endif
        end else begin : g_reg
            always_ff @(posedge clk) begin
                if (reset) begin
                    dout <= '0;
                end else if (rd_acc) begin
                    dout <= rd_word[WIDTH-1:0];
                end
            end
`ifdef SMALL_FIFO_PARITY_EN
            always_ff @(posedge clk) begin
                if (reset) begin
                    parity_err <= 1'b0;
                end else begin
                    parity_err <= rd_acc && ((^rd_word[WIDTH-1:0]) != rd_word[WIDTH]);
                end
            end
`endif
        end
    endgenerate

endmodule

// File: tb/tb_small_fifo_v3.sv
// Scoreboard bench for small_fifo_v3: registered-read and FWFT instances driven in lockstep.
module tb_small_fifo_v3;

    logic        clk;
    logic        reset;
    logic [15:0] din;
    logic        wr_en;
    logic        rd_en;

    logic [15:0] dout0, dout1;
    logic        full0, nf0, pf0, em0, pe0, ov0, un0;
    logic        full1, nf1, pf1, em1, pe1, ov1, un1;
    logic [2:0]  dc0, dc1;
    logic [9:0]  st0, st1;

`ifdef SMALL_FIFO_PARITY_EN
    logic par0, par1;
    bit   par_seen = 0;
`endif

    int vectors    = 0;
    int miscompares = 0;

    logic [15:0] sb[$];
    bit          m_ovf;
    bit          m_unf;
    logic [15:0] m_dout0;
    bit          rd_acc;

    small_fifo_v3 #(.WIDTH(16), .DEPTH(6), .PROG_FULL_THRESHOLD(4),
                    .PROG_EMPTY_THRESHOLD(1), .FWFT(0)) dut0 (
        .clk(clk), .reset(reset), .din(din), .wr_en(wr_en), .rd_en(rd_en),
        .dout(dout0), .full(full0), .nearly_full(nf0), .prog_full(pf0),
        .empty(em0), .prog_empty(pe0), .data_count(dc0),
        .overflow(ov0), .underflow(un0)
`ifdef SMALL_FIFO_PARITY_EN
        , .parity_err(par0)
`endif
    );

    small_fifo_v3 #(.WIDTH(16), .DEPTH(6), .PROG_FULL_THRESHOLD(4),
                    .PROG_EMPTY_THRESHOLD(1), .FWFT(1)) dut1 (
        .clk(clk), .reset(reset), .din(din), .wr_en(wr_en), .rd_en(rd_en),
        .dout(dout1), .full(full1), .nearly_full(nf1), .prog_full(pf1),
        .empty(em1), .prog_empty(pe1), .data_count(dc1),
        .overflow(ov1), .underflow(un1)
`ifdef SMALL_FIFO_PARITY_EN
        , .parity_err(par1)
`endif
    );

    assign st0 = {full0, nf0, pf0, em0, pe0, dc0, ov0, un0};
    assign st1 = {full1, nf1, pf1, em1, pe1, dc1, ov1, un1};

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef SMALL_FIFO_PARITY_EN
    always @(negedge clk) if (par0 === 1'b1 || par1 === 1'b1) par_seen = 1;
`endif

    // Expected {full, nearly_full, prog_full, empty, prog_empty, count, overflow, underflow}.
    function automatic logic [9:0] exp_status();
        int c;
        c = sb.size();
        return {c == 6, c >= 5, c >= 4, c == 0, c <= 1, 3'(c), m_ovf, m_unf};
    endfunction

    // One clock of stimulus; the reference queue is updated from pre-edge state.
    task automatic step(input logic r_s, input logic w, input logic r, input logic [15:0] d);
        bit full_m, empty_m;
        reset = r_s; wr_en = w; rd_en = r; din = d;
        @(posedge clk);
        #1;
        if (r_s) begin
            sb.delete();
            m_ovf = 0; m_unf = 0; m_dout0 = '0; rd_acc = 0;
        end else begin
            full_m  = (sb.size() == 6);
            empty_m = (sb.size() == 0);
            if (w && full_m) m_ovf = 1;
            if (r && empty_m) m_unf = 1;
            rd_acc = r && !empty_m;
            if (rd_acc) m_dout0 = sb.pop_front();
            if (w && !full_m) sb.push_back(d);
        end
        reset = 0; wr_en = 0; rd_en = 0;
    endtask

    task automatic test_reset();
        step(1, 0, 0, 16'h0);
        vectors++;
        if ({st0, st1} !== {10'b00011_000_00, 10'b00011_000_00}) begin
            miscompares++;
            $display("FAIL reset_status dut0=%b dut1=%b exp=%b", st0, st1, 10'b00011_000_00);
        end
        vectors++;
        if ({dout0, dout1} !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_dout dout0=%h dout1=%h exp=0000", dout0, dout1);
        end
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 7; i++) begin
            step(0, 1, 0, 16'(i));
            vectors++;
            if ({st0, st1} !== {exp_status(), exp_status()}) begin
                miscompares++;
                $display("FAIL fill_status write=%0d dut0=%b dut1=%b exp=%b", i, st0, st1, exp_status());
            end
            vectors++;
            if (dout1 !== 16'h0001) begin
                miscompares++;
                $display("FAIL fill_fwft_head write=%0d got=%h exp=0001", i, dout1);
            end
        end
    endtask

    task automatic test_drain_wrap();
        // 0=read, 1=write: pointers cross index 5 -> 0 on both sides.
        bit ops[20] = '{0,0,1,1,0,0,1,1,0,0,0,0,0,0,0,0,0,0,0,0};
        logic [15:0] wdat = 16'd7;
        int rd_idx = 1;
        for (int k = 0; k < 16; k++) begin
            if (ops[k]) begin
                step(0, 1, 0, wdat);
                wdat = wdat + 16'd1;
            end else begin
                step(0, 0, 1, 16'h0);
            end
            vectors++;
            if ({st0, st1} !== {exp_status(), exp_status()}) begin
                miscompares++;
                $display("FAIL drain_status op=%0d dut0=%b dut1=%b exp=%b", k, st0, st1, exp_status());
            end
            vectors++;
            if (dout0 !== m_dout0) begin
                miscompares++;
                $display("FAIL drain_dout0 op=%0d got=%h exp=%h", k, dout0, m_dout0);
            end
            if (rd_acc) begin
                vectors++;
                if (dout0 !== 16'(rd_idx)) begin
                    miscompares++;
                    $display("FAIL drain_order op=%0d got=%h exp=%h", k, dout0, 16'(rd_idx));
                end
                rd_idx++;
            end
            if (sb.size() != 0) begin
                vectors++;
                if (dout1 !== sb[0]) begin
                    miscompares++;
                    $display("FAIL drain_dout1 op=%0d got=%h exp=%h", k, dout1, sb[0]);
                end
            end
        end
        vectors++;
        if (rd_idx !== 11) begin
            miscompares++;
            $display("FAIL drain_words got=%0d exp=10", rd_idx - 1);
        end
    endtask

    task automatic test_simultaneous();
        step(1, 0, 0, 16'h0);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 16'h0100 + 16'(i));
        for (int i = 0; i < 19; i++) begin
            if (i < 8)       step(0, 1, 1, 16'h0200 + 16'(i));
            else if (i < 11) step(0, 1, 0, 16'h0300 + 16'(i));
            else if (i == 11) step(0, 1, 1, 16'h0400);
            else if (i < 17) step(0, 0, 1, 16'h0);
            else if (i == 17) step(0, 1, 1, 16'h0500);
            else              step(0, 0, 0, 16'h0);
            vectors++;
            if ({st0, st1} !== {exp_status(), exp_status()}) begin
                miscompares++;
                $display("FAIL simul_status cyc=%0d dut0=%b dut1=%b exp=%b", i, st0, st1, exp_status());
            end
            vectors++;
            if (dout0 !== m_dout0) begin
                miscompares++;
                $display("FAIL simul_dout0 cyc=%0d got=%h exp=%h", i, dout0, m_dout0);
            end
            if (sb.size() != 0) begin
                vectors++;
                if (dout1 !== sb[0]) begin
                    miscompares++;
                    $display("FAIL simul_dout1 cyc=%0d got=%h exp=%h", i, dout1, sb[0]);
                end
            end
        end
    endtask

    task automatic test_latency();
        step(1, 0, 0, 16'h0);
        step(0, 1, 0, 16'hABCD);
        vectors++;
        if ({em1, dout1} !== {1'b0, 16'hABCD}) begin
            miscompares++;
            $display("FAIL fwft_latency empty=%b dout=%h exp empty=0 dout=abcd", em1, dout1);
        end
        vectors++;
        if (dout0 !== 16'h0000) begin
            miscompares++;
            $display("FAIL reg_before_read got=%h exp=0000", dout0);
        end
        step(0, 0, 1, 16'h0);
        vectors++;
        if (dout0 !== 16'hABCD) begin
            miscompares++;
            $display("FAIL reg_latency got=%h exp=abcd", dout0);
        end
        step(0, 0, 0, 16'h0);
        step(0, 0, 1, 16'h0);
        vectors++;
        if ({dout0, un0, em0} !== {16'hABCD, 1'b1, 1'b1}) begin
            miscompares++;
            $display("FAIL reg_hold dout=%h underflow=%b empty=%b exp abcd 1 1", dout0, un0, em0);
        end
    endtask

    task automatic test_reset_mid();
        step(1, 0, 0, 16'h0);
        for (int i = 0; i < 7; i++) step(0, 1, 0, 16'h0600 + 16'(i));
        step(0, 0, 1, 16'h0);
        step(0, 0, 1, 16'h0);
        vectors++;
        if ({dc0, ov0, dc1, ov1} !== {3'd4, 1'b1, 3'd4, 1'b1}) begin
            miscompares++;
            $display("FAIL premid_state dut0=%0d/%b dut1=%0d/%b exp 4/1", dc0, ov0, dc1, ov1);
        end
        step(1, 1, 0, 16'h5555);
        vectors++;
        if ({st0, st1} !== {10'b00011_000_00, 10'b00011_000_00}) begin
            miscompares++;
            $display("FAIL midreset_status dut0=%b dut1=%b exp=%b", st0, st1, 10'b00011_000_00);
        end
        vectors++;
        if ({dout0, dout1} !== 32'h0) begin
            miscompares++;
            $display("FAIL midreset_dout dout0=%h dout1=%h exp=0000", dout0, dout1);
        end
    endtask

    initial begin
        reset = 1'b1; din = '0; wr_en = 1'b0; rd_en = 1'b0;
        m_ovf = 0; m_unf = 0; m_dout0 = '0; rd_acc = 0;
        test_reset();
        test_fill();
        test_drain_wrap();
        test_simultaneous();
        test_latency();
        test_reset_mid();
`ifdef SMALL_FIFO_PARITY_EN
        vectors++;
        if (par_seen !== 1'b0) begin
            miscompares++;
            $display("FAIL parity_quiet got=%b exp=0", par_seen);
        end
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
